// File: rtl/int_bus_arbiter_if.sv
// rtl/int_bus_arbiter_if.sv - two-master register-bus signal bundle for int_bus_arbiter
// arb_timeout exists only when ARB_TIMEOUT_EN is defined.
interface int_bus_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          a_req;
    logic          a_gnt;
    logic [AW-1:0] a_address;
    logic [DW-1:0] a_wr_data;
    logic          a_write;
    logic          a_read;
    logic [DW-1:0] a_rd_data;
    logic          a_rd_valid;

    logic          b_req;
    logic          b_gnt;
    logic [AW-1:0] b_address;
    logic [DW-1:0] b_wr_data;
    logic          b_write;
    logic          b_read;
    logic [DW-1:0] b_rd_data;
    logic          b_rd_valid;

    logic [AW-1:0] int_address;
    logic [DW-1:0] int_wr_data;
    logic          int_write;
    logic          int_read;
    logic [DW-1:0] int_rd_data;
`ifdef ARB_TIMEOUT_EN
    logic          arb_timeout;
`endif

    modport slave (
`ifdef ARB_TIMEOUT_EN
        output arb_timeout,
`endif
        input  a_req, a_address, a_wr_data, a_write, a_read,
        output a_gnt, a_rd_data, a_rd_valid,
        input  b_req, b_address, b_wr_data, b_write, b_read,
        output b_gnt, b_rd_data, b_rd_valid,
        output int_address, int_wr_data, int_write, int_read,
        input  int_rd_data
    );

    modport master (
`ifdef ARB_TIMEOUT_EN
        input  arb_timeout,
`endif
        output a_req, a_address, a_wr_data, a_write, a_read,
        input  a_gnt, a_rd_data, a_rd_valid,
        output b_req, b_address, b_wr_data, b_write, b_read,
        input  b_gnt, b_rd_data, b_rd_valid,
        input  int_address, int_wr_data, int_write, int_read,
        output int_rd_data
    );
endinterface

// File: rtl/int_bus_arbiter.sv
// rtl/int_bus_arbiter.sv - round-robin tenure arbiter sharing the register-file bus between two masters
// Optional forced release after TIMEOUT_CYCLES owned cycles: define ARB_TIMEOUT_EN.
module int_bus_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input logic              clock,
    input logic              reset,
    int_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t        state;
    state_t        state_next;
    logic          last_owner_b;
    logic          a_req_eff;
    logic          b_req_eff;
    logic          tag_valid;
    logic          tag_owner_b;
    logic [AW-1:0] mux_address;
    logic [DW-1:0] mux_wr_data;
    logic          mux_write;
    logic          mux_read;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] tenure;
    logic          timeout;
    logic          a_blocked;
    logic          b_blocked;

    assign timeout = (state != IDLE) && (tenure == CW'(TIMEOUT_CYCLES - 1));
    // A timing-out owner looks like it dropped req, so the normal handoff rules exclude it.
    assign a_req_eff = bus.a_req && !a_blocked && !(timeout && state == OWN_A);
    assign b_req_eff = bus.b_req && !b_blocked && !(timeout && state == OWN_B);

    always_ff @(posedge clock) begin
        if (reset) begin
            tenure          <= '0;
            a_blocked       <= 1'b0;
            b_blocked       <= 1'b0;
            bus.arb_timeout <= 1'b0;
        end else begin
            if (state_next != state)
                tenure <= '0;
            else if (state != IDLE)
                tenure <= tenure + 1'b1;
            bus.arb_timeout <= timeout;
            if (!bus.a_req)
                a_blocked <= 1'b0;
            else if (timeout && state == OWN_A)
                a_blocked <= 1'b1;
            if (!bus.b_req)
                b_blocked <= 1'b0;
            else if (timeout && state == OWN_B)
                b_blocked <= 1'b1;
        end
    end
`else
    assign a_req_eff = bus.a_req;
    assign b_req_eff = bus.b_req;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (a_req_eff && b_req_eff)
                    state_next = last_owner_b ? OWN_A : OWN_B;
                else if (a_req_eff)
                    state_next = OWN_A;
                else if (b_req_eff)
                    state_next = OWN_B;
            end
            OWN_A: if (!a_req_eff) state_next = b_req_eff ? OWN_B : IDLE;
            OWN_B: if (!b_req_eff) state_next = a_req_eff ? OWN_A : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes need the owner's req too, so a strobe in the req-drop cycle never escapes.
    always_comb begin
        mux_address = '0;
        mux_wr_data = '0;
        mux_write   = 1'b0;
        mux_read    = 1'b0;
        case (state)
            OWN_A: begin
                mux_address = bus.a_address;
                mux_wr_data = bus.a_wr_data;
                mux_write   = bus.a_write && bus.a_req;
                mux_read    = bus.a_read && !bus.a_write && bus.a_req;
            end
            OWN_B: begin
                mux_address = bus.b_address;
                mux_wr_data = bus.b_wr_data;
                mux_write   = bus.b_write && bus.b_req;
                mux_read    = bus.b_read && !bus.b_write && bus.b_req;
            end
            default: ;
        endcase
    end

    assign bus.int_address = mux_address;
    assign bus.int_wr_data = mux_wr_data;
    assign bus.int_write   = mux_write;
    assign bus.int_read    = mux_read;
    assign bus.a_gnt       = (state == OWN_A);
    assign bus.b_gnt       = (state == OWN_B);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            last_owner_b   <= 1'b1;
            tag_valid      <= 1'b0;
            tag_owner_b    <= 1'b0;
            bus.a_rd_valid <= 1'b0;
            bus.b_rd_valid <= 1'b0;
            bus.a_rd_data  <= '0;
            bus.b_rd_data  <= '0;
        end else begin
            state <= state_next;
            if (state_next != state && state_next != IDLE)
                last_owner_b <= (state_next == OWN_B);
            // The tag remembers the issuer so the return survives an ownership change.
            tag_valid      <= mux_read;
            tag_owner_b    <= (state == OWN_B);
            bus.a_rd_valid <= tag_valid && !tag_owner_b;
            bus.b_rd_valid <= tag_valid && tag_owner_b;
            if (tag_valid && !tag_owner_b)
                bus.a_rd_data <= bus.int_rd_data;
            if (tag_valid && tag_owner_b)
                bus.b_rd_data <= bus.int_rd_data;
        end
    end
endmodule
